// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-requester memory port
//            arbiter (FSM state encoding, owner ids, latency counter sizing).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CW      = $clog2(MEM_LAT_MAX + 1);

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr_pick
// Purpose  : Combinational two-way round-robin pick. A lone requester wins
//            outright; on a tie the requester that was not granted last wins.
// Ports    : cpu_req, host_req  - request levels
//            last_grant         - owner id of the previous grant
//            gnt_valid          - at least one request present
//            gnt_id             - winning owner id (OWN_CPU / OWN_HOST)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic host_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = cpu_req | host_req;
    gnt_id    = OWN_CPU;
    if (cpu_req && host_req) begin
      gnt_id = ~last_grant;
    end else if (host_req) begin
      gnt_id = OWN_HOST;
    end
  end

endmodule : mem_arb_rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the CPU (owner 0) and the
//            host loader (owner 1). Each access runs IDLE -> ISSUE -> WAIT ->
//            DONE with a fixed read latency of MEM_LAT cycles; writes skip WAIT.
// Ports    : CLK, Reset (sync, active-high)
//            cpu_*  : req/we/addr/wdata in, rdata/done out
//            host_* : req/we/addr/wdata in, rdata/done out
//            mem_*  : en/we/addr/wdata out, rdata in
//            busy   : high outside IDLE
//            cpu_wait_cnt (only with ARB_PERF_CNT_EN): saturating count of
//            cycles the CPU requested while the host held the port
// Config   : ARB_PERF_CNT_EN - enables the cpu_wait_cnt output and counter
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]   cpu_wait_cnt,
`endif
  output logic          busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT out of range 1..4");
    end
  endgenerate

  arb_state_t        state, state_nxt;
  logic [LAT_CW-1:0] lat_cnt, lat_cnt_nxt;
  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [AW-1:0]     lat_addr;
  logic [DW-1:0]     lat_wdata;
  logic              gnt_valid;
  logic              gnt_id;
  logic              grant;
  logic              capture;

  mem_arb_rr_pick u_pick (
    .cpu_req    (cpu_req),
    .host_req   (host_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Requests are only looked at in IDLE, so anything the requesters do
  // after the grant cannot disturb the access in flight.
  assign grant   = (state == IDLE) && gnt_valid;
  // Read data is valid in the last WAIT cycle (lat_cnt == 1).
  assign capture = (state == WAIT) && (lat_cnt == LAT_CW'(1));

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      IDLE: begin
        if (gnt_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (lat_we) begin
          state_nxt = DONE;
        end else begin
          lat_cnt_nxt = LAT_CW'(MEM_LAT);
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_nxt = lat_cnt - LAT_CW'(1);
        if (lat_cnt == LAT_CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      last_grant <= OWN_HOST;   // CPU wins the first tie
      owner      <= OWN_CPU;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (grant) begin
        last_grant <= gnt_id;
        owner      <= gnt_id;
        lat_we     <= (gnt_id == OWN_HOST) ? host_we    : cpu_we;
        lat_addr   <= (gnt_id == OWN_HOST) ? host_addr  : cpu_addr;
        lat_wdata  <= (gnt_id == OWN_HOST) ? host_wdata : cpu_wdata;
      end
      if (capture) begin
        if (owner == OWN_HOST) host_rdata <= mem_rdata;
        else                   cpu_rdata  <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_done  = (state == DONE) && (owner == OWN_CPU);
  assign host_done = (state == DONE) && (owner == OWN_HOST);
  assign busy      = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  // CPU is waiting when it requests in an IDLE cycle the host wins, or in
  // any cycle of an access the host owns.
  logic cpu_waiting;
  assign cpu_waiting = cpu_req &&
                       ((grant && (gnt_id == OWN_HOST)) ||
                        ((state != IDLE) && (owner == OWN_HOST)));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cpu_wait_cnt <= '0;
    end else if (cpu_waiting && (cpu_wait_cnt != 16'hFFFF)) begin
      cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
    end
  end
`else
  // Performance counter not built.
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Instance a_
//            runs with MEM_LAT=1, instance b_ with MEM_LAT=4; each has a small
//            fixed-latency memory model. Inputs are driven and outputs sampled
//            on the falling edge.
// Config   : ARB_PERF_CNT_EN - also checks cpu_wait_cnt on instance a_
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- instance a_ (MEM_LAT = 1) ----------------
  logic        a_cpu_req, a_cpu_we, a_cpu_done, a_host_req, a_host_we, a_host_done;
  logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic [15:0] a_host_addr, a_host_wdata, a_host_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] a_wait_cnt;
`endif

  mem_port_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u_dut_a (
    .CLK(clk), .Reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done),
    .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr),
    .host_wdata(a_host_wdata), .host_rdata(a_host_rdata), .host_done(a_host_done),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .cpu_wait_cnt(a_wait_cnt),
`endif
    .busy(a_busy)
  );

  // ---------------- instance b_ (MEM_LAT = 4) ----------------
  logic        b_cpu_req, b_cpu_we, b_cpu_done, b_host_req, b_host_we, b_host_done;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic [15:0] b_host_addr, b_host_wdata, b_host_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] b_wait_cnt;
`endif

  mem_port_arbiter #(.MEM_LAT(4), .AW(16), .DW(16)) u_dut_b (
    .CLK(clk), .Reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr),
    .host_wdata(b_host_wdata), .host_rdata(b_host_rdata), .host_done(b_host_done),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .cpu_wait_cnt(b_wait_cnt),
`endif
    .busy(b_busy)
  );

  // ---------------- memory models ----------------
  // Read data is valid only in the cycle MEM_LAT after mem_en; otherwise
  // the models drive 16'hDEAD so early or late capture is visible.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        a_rv;
  logic [15:0] a_rd;
  logic [3:0]  b_v;
  logic [15:0] b_p [0:3];
  int          a_wr_cnt = 0;
  logic [15:0] a_wr_addr, a_wr_data;

  always @(posedge clk) begin
    a_rv <= a_mem_en && !a_mem_we;
    a_rd <= mem_a[a_mem_addr[7:0]];
    if (a_mem_en && a_mem_we) begin
      a_wr_cnt  <= a_wr_cnt + 1;
      a_wr_addr <= a_mem_addr;
      a_wr_data <= a_mem_wdata;
    end
    b_v    <= {b_v[2:0], b_mem_en && !b_mem_we};
    b_p[0] <= mem_b[b_mem_addr[7:0]];
    b_p[1] <= b_p[0];
    b_p[2] <= b_p[1];
    b_p[3] <= b_p[2];
  end

  assign a_mem_rdata = a_rv   ? a_rd   : 16'hDEAD;
  assign b_mem_rdata = b_v[3] ? b_p[3] : 16'hDEAD;

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[8'h10] = 16'hBEEF;
    mem_a[8'h20] = 16'h1111;
    mem_b[8'h40] = 16'h5A5A;

    reset = 1'b1;
    {a_cpu_req, a_cpu_we, a_host_req, a_host_we} = '0;
    {b_cpu_req, b_cpu_we, b_host_req, b_host_we} = '0;
    {a_cpu_addr, a_cpu_wdata, a_host_addr, a_host_wdata} = '0;
    {b_cpu_addr, b_cpu_wdata, b_host_addr, b_host_wdata} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_busy",      a_busy,       0);
    chk("rst_mem_en",    a_mem_en,     0);
    chk("rst_mem_addr",  a_mem_addr,   0);
    chk("rst_cpu_rdata", a_cpu_rdata,  0);
    chk("rst_dones",     {a_cpu_done, a_host_done, b_cpu_done, b_host_done}, 0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_wait_cnt",  a_wait_cnt,   0);
`endif

    // 1. CPU read of 0x0010, MEM_LAT=1
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 16'h0010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_mem_en_%0d", k),    a_mem_en,    (k == 1));
      chk($sformatf("t1_cpu_done_%0d", k),  a_cpu_done,  (k == 3));
      chk($sformatf("t1_host_done_%0d", k), a_host_done, 0);
      if (k == 1) chk("t1_mem_addr", a_mem_addr, 16'h0010);
      if (k == 3) begin
        chk("t1_cpu_rdata", a_cpu_rdata, 16'hBEEF);
        a_cpu_req = 1'b0;
      end
    end

    // 2. Host write 0x1234 to 0x00FF
    a_host_req = 1'b1; a_host_we = 1'b1; a_host_addr = 16'h00FF; a_host_wdata = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t2_mem_we_%0d", k),    a_mem_we,    (k == 1));
      chk($sformatf("t2_host_done_%0d", k), a_host_done, (k == 2));
      chk($sformatf("t2_cpu_done_%0d", k),  a_cpu_done,  0);
      if (k == 1) begin
        chk("t2_mem_addr",  a_mem_addr,  16'h00FF);
        chk("t2_mem_wdata", a_mem_wdata, 16'h1234);
      end
      if (k == 2) a_host_req = 1'b0;
    end
    chk("t2_wr_cnt",    a_wr_cnt,    1);
    chk("t2_wr_data",   a_wr_data,   16'h1234);
    chk("t2_cpu_rdata", a_cpu_rdata, 16'hBEEF);

    // 3. Both requesters held high after reset: CPU, host, CPU, host
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a_cpu_req  = 1'b1; a_cpu_we  = 1'b0; a_cpu_addr  = 16'h0020;
    a_host_req = 1'b1; a_host_we = 1'b1; a_host_addr = 16'h0030; a_host_wdata = 16'h7777;
    for (int n = 0; n < 4; n++) begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(a_cpu_done || a_host_done) && w < 10);
      chk($sformatf("t3_cpu_done_%0d", n),  a_cpu_done,  (n % 2 == 0));
      chk($sformatf("t3_host_done_%0d", n), a_host_done, (n % 2 == 1));
      if (n % 2 == 0) chk($sformatf("t3_cpu_rdata_%0d", n), a_cpu_rdata, 16'h1111);
    end
    a_cpu_req = 1'b0; a_host_req = 1'b0;
    @(negedge clk);
    chk("t3_done_pulse", {a_cpu_done, a_host_done}, 0);
    chk("t3_wr_cnt",     a_wr_cnt, 3);

    // 4. Host read with MEM_LAT=4 returning 0x5A5A
    b_host_req = 1'b1; b_host_we = 1'b0; b_host_addr = 16'h0040;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t4_busy_%0d", k),      b_busy,      (k <= 6));
      chk($sformatf("t4_host_done_%0d", k), b_host_done, (k == 6));
      chk($sformatf("t4_mem_en_%0d", k),    b_mem_en,    (k == 1));
      if (k == 6) begin
        chk("t4_host_rdata", b_host_rdata, 16'h5A5A);
        chk("t4_cpu_rdata",  b_cpu_rdata,  0);
        b_host_req = 1'b0;
      end
    end

    // 5. Reset during WAIT of a CPU read (MEM_LAT=4)
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 16'h0040;
    repeat (3) @(negedge clk);
    chk("t5_in_wait", b_busy, 1);
    reset = 1'b1; b_cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy",       b_busy,       0);
    chk("t5_mem_en",     b_mem_en,     0);
    chk("t5_cpu_rdata",  b_cpu_rdata,  0);
    chk("t5_host_rdata", b_host_rdata, 0);
    begin
      logic seen;
      seen = b_cpu_done;
      repeat (6) begin
        @(negedge clk);
        seen = seen | b_cpu_done;
      end
      chk("t5_no_cpu_done", seen, 0);
    end

    // 6. CPU write, then host wins a tie; CPU waits through the host read
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 16'h0050; a_cpu_wdata = 16'h4242;
    repeat (2) @(negedge clk);
    chk("t6_cpu_wr_done", a_cpu_done, 1);
    a_cpu_req = 1'b0;
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("t6_cnt_before", a_wait_cnt, 0);
`endif
    a_cpu_req  = 1'b1; a_cpu_we  = 1'b0; a_cpu_addr  = 16'h0020;
    a_host_req = 1'b1; a_host_we = 1'b0; a_host_addr = 16'h0010;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t6_host_done_%0d", k), a_host_done, (k == 3));
      chk($sformatf("t6_mem_en_%0d", k),    a_mem_en,    (k == 1 || k == 5));
      if (k == 3) begin
        chk("t6_host_rdata", a_host_rdata, 16'hBEEF);
        a_host_req = 1'b0;
      end
`ifdef ARB_PERF_CNT_EN
      if (k == 4) chk("t6_wait_cnt", a_wait_cnt, 4);
      if (k == 5) chk("t6_wait_cnt_hold", a_wait_cnt, 4);
`endif
    end
    repeat (2) @(negedge clk);
    chk("t6_cpu_done", a_cpu_done, 1);
    chk("t6_cpu_rdata", a_cpu_rdata, 16'h1111);
    a_cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
